// File: rtl/ldr_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ldr_input_conditioner
// Purpose  : Front end for the three LDR comparator pins. Each pin is
//            synchronised into CLOCK_50 and debounced by its own stable-time
//            counter. The stage outputs clean levels and one-cycle rise/fall
//            strobes. It also keeps a saturating count of background-LDR
//            (jump) rising events.
// Ports    : CLOCK_50   - 50 MHz system clock, rising edge
//            RESET      - synchronous active-high reset
//            GPILDR1..3 - raw asynchronous comparator inputs
//            COUNT_CLR  - synchronous clear of JUMP_COUNT
//            LDR_CLEAN  - debounced levels, bit0=GPILDR1 .. bit2=GPILDR3
//            LDR_RISE   - one-cycle strobe on CLEAN 0->1, per channel
//            LDR_FALL   - one-cycle strobe on CLEAN 1->0, per channel
//            JUMP_COUNT - saturating count of LDR_RISE[0] events
// Revision : 1.0 - initial release
// ============================================================================
module ldr_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int EVT_W           = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             GPILDR1,
    input  logic             GPILDR2,
    input  logic             GPILDR3,
    input  logic             COUNT_CLR,
    output logic [2:0]       LDR_CLEAN,
    output logic [2:0]       LDR_RISE,
    output logic [2:0]       LDR_FALL,
    output logic [EVT_W-1:0] JUMP_COUNT
);

    // The counter reaches this value on the last cycle before CLEAN is allowed to follow.
    localparam logic [CNT_W-1:0] c_TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [EVT_W-1:0] c_EVT_MAX  = '1;

    logic [2:0]       w_raw;
    logic [2:0]       s1_q;
    logic [2:0]       s2_q;
    logic [2:0]       clean_q;
    logic [2:0]       clean_d;
    logic [2:0]       rise_q;
    logic [2:0]       rise_d;
    logic [2:0]       fall_q;
    logic [2:0]       fall_d;
    logic [EVT_W-1:0] jump_q;
    logic [EVT_W-1:0] jump_d;

    assign w_raw = {GPILDR3, GPILDR2, GPILDR1};

    // Synchroniser plus registered debounce outputs shared by all channels.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s1_q    <= '0;
            s2_q    <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            jump_q  <= '0;
        end else begin
            s1_q    <= w_raw;
            s2_q    <= s1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            jump_q  <= jump_d;
        end
    end

    // Per-channel stable-time debounce. Whenever the input matches CLEAN, the count restarts from zero.
    generate
        for (genvar i = 0; i < 3; i++) begin : g_ch
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             ch_clean_d;
            logic             ch_rise_d;
            logic             ch_fall_d;

            always_comb begin
                cnt_d      = '0;
                ch_clean_d = clean_q[i];
                ch_rise_d  = 1'b0;
                ch_fall_d  = 1'b0;
                if (s2_q[i] != clean_q[i]) begin
                    if (cnt_q == c_TERM_CNT) begin
                        ch_clean_d = s2_q[i];
                        ch_rise_d  = s2_q[i];
                        ch_fall_d  = ~s2_q[i];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge CLOCK_50) begin
                if (RESET) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign clean_d[i] = ch_clean_d;
            assign rise_d[i]  = ch_rise_d;
            assign fall_d[i]  = ch_fall_d;
        end
    endgenerate

    // The count advances on the same edge that registers RISE[0], so it already includes that event while the strobe is high.
    // If a clear arrives in that same cycle, the clear takes priority.
    always_comb begin
        jump_d = jump_q;
        if (COUNT_CLR) begin
            jump_d = '0;
        end else if (rise_d[0] && (jump_q != c_EVT_MAX)) begin
            jump_d = jump_q + EVT_W'(1);
        end
    end

    assign LDR_CLEAN  = clean_q;
    assign LDR_RISE   = rise_q;
    assign LDR_FALL   = fall_q;
    assign JUMP_COUNT = jump_q;

endmodule
`default_nettype wire

// File: tb/tb_ldr_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldr_input_conditioner
// Purpose  : Directed bench for ldr_input_conditioner with DEBOUNCE_CYCLES=4.
//            Each input change the bench drives pushes the strobe event it
//            should cause onto a queue. A negedge monitor pops and checks
//            every strobe the design emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldr_input_conditioner;

    localparam int c_DEB   = 4;
    localparam int c_CNT_W = 16;
    localparam int c_EVT_W = 8;
    // An input driven just after edge n produces its strobe at edge n + 1 + c_DEB + 1.
    localparam int c_LAT   = c_DEB + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_l1 = 1'b0;
    logic             i_l2 = 1'b0;
    logic             i_l3 = 1'b0;
    logic             i_clr = 1'b0;
    logic [2:0]       o_clean;
    logic [2:0]       o_rise;
    logic [2:0]       o_fall;
    logic [c_EVT_W-1:0] o_jump;

    typedef struct packed {
        logic [31:0]        cyc;
        logic [2:0]         rise;
        logic [2:0]         fall;
        logic [2:0]         clean;
        logic [c_EVT_W-1:0] jump;
    } ev_t;

    ev_t              q[$];
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    logic [2:0]       exp_clean = '0;
    int               exp_jump = 0;

    ldr_input_conditioner #(
        .DEBOUNCE_CYCLES(c_DEB),
        .CNT_W          (c_CNT_W),
        .EVT_W          (c_EVT_W)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .GPILDR1   (i_l1),
        .GPILDR2   (i_l2),
        .GPILDR3   (i_l3),
        .COUNT_CLR (i_clr),
        .LDR_CLEAN (o_clean),
        .LDR_RISE  (o_rise),
        .LDR_FALL  (o_fall),
        .JUMP_COUNT(o_jump)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance n edges and return 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Record the strobe event expected from an input change driven now.
    task automatic push(input logic [2:0] rise, input logic [2:0] fall, input bit clr);
        ev_t e;
        exp_clean = (exp_clean | rise) & ~fall;
        if (clr) exp_jump = 0;
        else if (rise[0] && exp_jump != 255) exp_jump++;
        e.cyc   = 32'(cyc + c_LAT);
        e.rise  = rise;
        e.fall  = fall;
        e.clean = exp_clean;
        e.jump  = c_EVT_W'(exp_jump);
        q.push_back(e);
    endtask

    // Every strobe the design emits must match the next expected event.
    always @(negedge clk) begin
        if (!rst && ((o_rise | o_fall) != 3'b000)) begin
            check("rise_and_fall_exclusive", 32'(o_rise & o_fall), 32'd0);
            if (q.size() == 0) begin
                check("unexpected_strobe", {26'd0, o_rise, o_fall}, 32'd0);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("strobe_cycle", 32'(cyc), e.cyc);
                check("rise", 32'(o_rise), 32'(e.rise));
                check("fall", 32'(o_fall), 32'(e.fall));
                check("clean", 32'(o_clean), 32'(e.clean));
                check("jump_count", 32'(o_jump), 32'(e.jump));
            end
        end
    end

    initial begin
        // Reset state
        tick(3);
        check("reset_clean", 32'(o_clean), 32'd0);
        check("reset_rise", 32'(o_rise), 32'd0);
        check("reset_fall", 32'(o_fall), 32'd0);
        check("reset_jump", 32'(o_jump), 32'd0);
        rst = 1'b0;
        tick(3);

        // Single clean rise and fall on channel 0
        i_l1 = 1'b1; push(3'b001, 3'b000, 1'b0);
        tick(10);
        check("ch0_clean_high", 32'(o_clean), 32'b001);
        check("ch0_jump_one", 32'(o_jump), 32'd1);
        i_l1 = 1'b0; push(3'b000, 3'b001, 1'b0);
        tick(10);

        // 3-cycle glitch on channel 1 is filtered out
        i_l2 = 1'b1; tick(3);
        i_l2 = 1'b0; tick(10);
        check("glitch_filtered", 32'(o_clean), 32'b000);

        // High pulse with a 1-cycle dip: debounce restarts when the input comes back
        i_l2 = 1'b1; tick(3);
        i_l2 = 1'b0; tick(1);
        i_l2 = 1'b1; push(3'b010, 3'b000, 1'b0);
        tick(10);
        check("ch1_clean_after_dip", 32'(o_clean), 32'b010);
        i_l2 = 1'b0; push(3'b000, 3'b010, 1'b0);
        tick(10);

        // All channels together
        i_l1 = 1'b1; i_l2 = 1'b1; i_l3 = 1'b1; push(3'b111, 3'b000, 1'b0);
        tick(10);
        i_l1 = 1'b0; i_l2 = 1'b0; i_l3 = 1'b0; push(3'b000, 3'b111, 1'b0);
        tick(10);

        // Saturation: 300 debounced pulses on channel 0
        for (int k = 0; k < 300; k++) begin
            i_l1 = 1'b1; push(3'b001, 3'b000, 1'b0);
            tick(6);
            i_l1 = 1'b0; push(3'b000, 3'b001, 1'b0);
            tick(6);
        end
        tick(6);
        check("jump_saturated", 32'(o_jump), 32'd255);

        // Clear on the same edge that registers RISE[0]
        i_l1 = 1'b1; push(3'b001, 3'b000, 1'b1);
        tick(c_LAT - 1);
        i_clr = 1'b1; tick(1);
        i_clr = 1'b0;
        check("clear_wins", 32'(o_jump), 32'd0);
        tick(5);
        i_l1 = 1'b0; push(3'b000, 3'b001, 1'b0);
        tick(10);
        i_l1 = 1'b1; push(3'b001, 3'b000, 1'b0);
        tick(10);
        check("count_after_clear", 32'(o_jump), 32'd1);

        // Reset at cnt=2 on channel 2. After release, both high inputs re-debounce.
        i_l3 = 1'b1; tick(4);
        rst = 1'b1; tick(1);
        check("midreset_clean", 32'(o_clean), 32'd0);
        check("midreset_rise", 32'(o_rise), 32'd0);
        check("midreset_fall", 32'(o_fall), 32'd0);
        check("midreset_jump", 32'(o_jump), 32'd0);
        rst = 1'b0;
        exp_clean = 3'b000; exp_jump = 0;
        push(3'b101, 3'b000, 1'b0);
        tick(c_LAT - 1);
        check("post_reset_not_yet", 32'(o_clean), 32'd0);
        tick(10);
        check("post_reset_clean", 32'(o_clean), 32'b101);

        check("all_events_seen", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldr_input_conditioner.md
Name: ldr_input_conditioner

Overview:
Front-end stage for the LDR sensor pins. It sits directly upstream of the key-driver logic that asserts SPACEBAR/DOWNKEY. It synchronises the three asynchronous LDR comparator inputs into CLOCK_50 and debounces each one with a per-channel stable-time counter. It then presents clean levels plus single-cycle rising-edge strobes to the key driver, and keeps a saturating count of background-LDR (jump) events for display on LEDG.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive CLOCK_50 cycles an input must hold a new level before CLEAN follows (1 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 16, width of each per-channel debounce counter
EVT_W, 8, width of JUMP_COUNT

Ports:
CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge
RESET  input  1  synchronous, active-high reset
GPILDR1  input  1  raw background LDR comparator (asynchronous)
GPILDR2  input  1  raw first foreground LDR comparator (asynchronous)
GPILDR3  input  1  raw second foreground LDR comparator (asynchronous)
COUNT_CLR  input  1  synchronous clear of JUMP_COUNT
LDR_CLEAN  output  3  debounced levels; bit0=GPILDR1, bit1=GPILDR2, bit2=GPILDR3
LDR_RISE  output  3  one-cycle strobe per channel on CLEAN 0->1
LDR_FALL  output  3  one-cycle strobe per channel on CLEAN 1->0
JUMP_COUNT  output  EVT_W  saturating count of LDR_RISE[0] events

Behaviour:
- Reset (RESET high at an edge): both sync flops, LDR_CLEAN, LDR_RISE, LDR_FALL, all debounce counters and JUMP_COUNT go to 0. Reset overrides every other action, including mid-debounce.
- Synchroniser: 2-flop chain per channel (s1 <= GPILDRn, s2 <= s1). Only s2 feeds the debounce logic.
- Debounce, per channel, each edge:
  - s2 == CLEAN: cnt <= 0.
  - s2 != CLEAN and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != CLEAN and cnt == DEBOUNCE_CYCLES-1: CLEAN <= s2, cnt <= 0.
  - Any return of s2 to CLEAN before terminal count restarts the count from 0. No partial credit is kept.
- Latency: input stable at the new level before edge k -> CLEAN changes at edge k+DEBOUNCE_CYCLES+1.
- Filtering: a pulse held for fewer than DEBOUNCE_CYCLES s2-cycles never reaches CLEAN.
- RISE/FALL:
  - Registered, and asserted on the same edge where CLEAN changes.
  - High for exactly one cycle.
  - RISE and FALL of one channel are never high together.
  - Back-to-back strobes on one channel are impossible; they are at least DEBOUNCE_CYCLES apart.
- Channels are fully independent. Simultaneous changes on several channels each produce their own strobe in the same cycle.
- JUMP_COUNT:
  - Increments by 1 on each LDR_RISE[0].
  - Saturates at 2^EVT_W-1 and never wraps.
  - COUNT_CLR sets it to 0. If COUNT_CLR and LDR_RISE[0] occur in the same cycle, clear wins and the result is 0.
- After reset release with an input already high: treated as a new 0->1 transition. CLEAN rises at edge r+DEBOUNCE_CYCLES+1, where r is the first edge with RESET low, and RISE fires.
- No combinational path from any input to any output.

Test Plan:
- DEBOUNCE_CYCLES=4; reset, then GPILDR1 0->1 held before edge 10 -> LDR_CLEAN[0]=1 and LDR_RISE[0]=1 at edge 15 only; JUMP_COUNT=1 after edge 15.
- DEBOUNCE_CYCLES=4; GPILDR2 glitch high for 3 cycles, then a 1-cycle low inside a 10-cycle high -> no change during the glitch; after the low dip, CLEAN[1] rises exactly 5 edges after the input returns high; exactly one RISE[1].
- All three inputs rise together, then fall together -> LDR_RISE=3'b111 on one edge and LDR_FALL=3'b111 on one later edge; never RISE&FALL on the same bit.
- EVT_W=8; 300 debounced GPILDR1 pulses -> JUMP_COUNT stops at 255. Then COUNT_CLR asserted on the same edge as a RISE[0] -> JUMP_COUNT=0.
- RESET asserted for 1 cycle at cnt=2 while GPILDR3 is high -> all outputs 0 next edge. CLEAN[2] rises DEBOUNCE_CYCLES+1 edges after reset deasserts, with one RISE[2].
